// File: rtl/sap1_controller.sv
`default_nettype none
// ============================================================================
// sap1_controller : SAP-1 T1..T6 ring sequencer and opcode control decode
// Revision 1.0
// ============================================================================
module sap1_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       out_load,
  output logic       alu_mode,
  output logic       alu_enable,
  output logic [2:0] t_state,
  output logic       instr_done,
  output logic       halted
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Encoding doubles as the t_state output: HALT reads 0, Tn reads n.
  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_T1;
      halted <= 1'b0;
    end else if (run) begin
      case (state)
        S_T1: state <= S_T2;
        S_T2: state <= S_T3;
        S_T3: state <= S_T4;
        S_T4: begin
          if (opcode == OP_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_T5;
          end
        end
        S_T5:    state <= S_T6;
        S_T6:    state <= S_T1;
        default: state <= state;
      endcase
    end
  end

  assign t_state = state;

  // Control word is only driven in an active run cycle outside reset.
  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    mar_load   = 1'b0;
    ram_out    = 1'b0;
    ir_load    = 1'b0;
    ir_out     = 1'b0;
    a_load     = 1'b0;
    a_out      = 1'b0;
    b_load     = 1'b0;
    out_load   = 1'b0;
    alu_mode   = 1'b0;
    alu_enable = 1'b0;
    instr_done = 1'b0;
    if (rst_n && run) begin
      case (state)
        S_T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        S_T2: pc_inc = 1'b1;
        S_T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        S_T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out  = 1'b1;
              b_load   = 1'b1;
              alu_mode = (opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        S_T6: begin
          instr_done = 1'b1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_enable = 1'b1;
            a_load     = 1'b1;
            alu_mode   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sap1_controller.sv
`default_nettype none
// ============================================================================
// tb_sap1_controller : directed-vector bench for sap1_controller
// Revision 1.0
// ============================================================================
module tb_sap1_controller;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, out_load, alu_mode, alu_enable;
  logic [2:0] t_state;
  logic       instr_done;
  logic       halted;

  int tests = 0;
  int fails = 0;

  sap1_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .pc_out     (pc_out),
    .pc_inc     (pc_inc),
    .mar_load   (mar_load),
    .ram_out    (ram_out),
    .ir_load    (ir_load),
    .ir_out     (ir_out),
    .a_load     (a_load),
    .a_out      (a_out),
    .b_load     (b_load),
    .out_load   (out_load),
    .alu_mode   (alu_mode),
    .alu_enable (alu_enable),
    .t_state    (t_state),
    .instr_done (instr_done),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit order:
  // pc_out pc_inc mar_load ram_out ir_load ir_out a_load a_out b_load out_load alu_mode alu_enable
  localparam logic [11:0] W_NONE  = 12'h000;
  localparam logic [11:0] W_T1    = 12'hA00;
  localparam logic [11:0] W_T2    = 12'h400;
  localparam logic [11:0] W_T3    = 12'h180;
  localparam logic [11:0] W_ADDR  = 12'h240;
  localparam logic [11:0] W_LDA5  = 12'h120;
  localparam logic [11:0] W_ADD5  = 12'h108;
  localparam logic [11:0] W_ADD6  = 12'h021;
  localparam logic [11:0] W_SUB5  = 12'h10A;
  localparam logic [11:0] W_SUB6  = 12'h023;
  localparam logic [11:0] W_OUT4  = 12'h014;

  logic [11:0] ctrl;
  assign ctrl = {pc_out, pc_inc, mar_load, ram_out, ir_load, ir_out,
                 a_load, a_out, b_load, out_load, alu_mode, alu_enable};

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; checks run mid-cycle, then
  // the task advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] exp_t, input logic [11:0] exp_ctrl,
                     input logic exp_done, input logic exp_halt);
    logic [11:0] drv_ok;
    #2;
    drv_ok = {11'd0, ($countones({pc_out, ram_out, ir_out, a_out, alu_enable}) <= 1)};
    check({tag, ".t_state"}, {9'd0, t_state}, {9'd0, exp_t});
    check({tag, ".ctrl"}, ctrl, exp_ctrl);
    check({tag, ".done"}, {11'd0, instr_done}, {11'd0, exp_done});
    check({tag, ".halted"}, {11'd0, halted}, {11'd0, exp_halt});
    check({tag, ".one_driver"}, drv_ok, 12'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    run    = 1'b1;
    opcode = 4'h0;
    @(posedge clk);
    #1;

    // Reset held two cycles with run high
    cyc("rst0", 3'd1, W_NONE, 1'b0, 1'b0);
    cyc("rst1", 3'd1, W_NONE, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ADD
    opcode = 4'h1;
    cyc("add_t1", 3'd1, W_T1,   1'b0, 1'b0);
    cyc("add_t2", 3'd2, W_T2,   1'b0, 1'b0);
    cyc("add_t3", 3'd3, W_T3,   1'b0, 1'b0);
    cyc("add_t4", 3'd4, W_ADDR, 1'b0, 1'b0);
    cyc("add_t5", 3'd5, W_ADD5, 1'b0, 1'b0);
    cyc("add_t6", 3'd6, W_ADD6, 1'b1, 1'b0);

    // Two SUB instructions back to back
    opcode = 4'h2;
    for (int k = 0; k < 2; k++) begin
      cyc("sub_t1", 3'd1, W_T1,   1'b0, 1'b0);
      cyc("sub_t2", 3'd2, W_T2,   1'b0, 1'b0);
      cyc("sub_t3", 3'd3, W_T3,   1'b0, 1'b0);
      cyc("sub_t4", 3'd4, W_ADDR, 1'b0, 1'b0);
      cyc("sub_t5", 3'd5, W_SUB5, 1'b0, 1'b0);
      cyc("sub_t6", 3'd6, W_SUB6, 1'b1, 1'b0);
    end

    // LDA with a 3-cycle stall at T5
    opcode = 4'h0;
    cyc("lda_t1", 3'd1, W_T1,   1'b0, 1'b0);
    cyc("lda_t2", 3'd2, W_T2,   1'b0, 1'b0);
    cyc("lda_t3", 3'd3, W_T3,   1'b0, 1'b0);
    cyc("lda_t4", 3'd4, W_ADDR, 1'b0, 1'b0);
    run = 1'b0;
    cyc("lda_stall0", 3'd5, W_NONE, 1'b0, 1'b0);
    cyc("lda_stall1", 3'd5, W_NONE, 1'b0, 1'b0);
    cyc("lda_stall2", 3'd5, W_NONE, 1'b0, 1'b0);
    run = 1'b1;
    cyc("lda_t5", 3'd5, W_LDA5, 1'b0, 1'b0);
    cyc("lda_t6", 3'd6, W_NONE, 1'b1, 1'b0);

    // HLT
    opcode = 4'hF;
    cyc("hlt_t1", 3'd1, W_T1,   1'b0, 1'b0);
    cyc("hlt_t2", 3'd2, W_T2,   1'b0, 1'b0);
    cyc("hlt_t3", 3'd3, W_T3,   1'b0, 1'b0);
    cyc("hlt_t4", 3'd4, W_NONE, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      opcode = 4'($urandom_range(0, 15));
      cyc("halt", 3'd0, W_NONE, 1'b0, 1'b1);
    end
    rst_n = 1'b0;
    cyc("halt_rst", 3'd0, W_NONE, 1'b0, 1'b1);
    rst_n = 1'b1;

    // OUT interrupted by reset in T5
    opcode = 4'hE;
    cyc("out_t1", 3'd1, W_T1,   1'b0, 1'b0);
    cyc("out_t2", 3'd2, W_T2,   1'b0, 1'b0);
    cyc("out_t3", 3'd3, W_T3,   1'b0, 1'b0);
    cyc("out_t4", 3'd4, W_OUT4, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc("out_rst", 3'd5, W_NONE, 1'b0, 1'b0);
    rst_n = 1'b1;

    // NOP; opcode changes during fetch must not matter
    opcode = 4'h1;
    cyc("nop_t1", 3'd1, W_T1,   1'b0, 1'b0);
    opcode = 4'hF;
    cyc("nop_t2", 3'd2, W_T2,   1'b0, 1'b0);
    opcode = 4'hE;
    cyc("nop_t3", 3'd3, W_T3,   1'b0, 1'b0);
    opcode = 4'h7;
    cyc("nop_t4", 3'd4, W_NONE, 1'b0, 1'b0);
    cyc("nop_t5", 3'd5, W_NONE, 1'b0, 1'b0);
    cyc("nop_t6", 3'd6, W_NONE, 1'b1, 1'b0);
    cyc("nop_next", 3'd1, W_T1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
